sample_iter_ctrl: RTL and testbench



---
 rtl/sample_iter_ctrl_pkg.sv | 41 ++++
 rtl/sample_iter_ctrl_iter_step.sv | 34 +++
 rtl/sample_iter_ctrl.sv | 117 +++++++++++
 tb/tb_sample_iter_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_iter_ctrl_pkg.sv
// Shared types and helpers for the rasterizer sample iterator.
// Optional statistics counters are enabled with ITER_STATS_EN.
package sample_iter_ctrl_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef enum logic {
        WAIT,
        TEST
    } state_t;

    localparam logic [3:0] SS_1  = 4'b1000;
    localparam logic [3:0] SS_4  = 4'b0100;
    localparam logic [3:0] SS_16 = 4'b0010;
    localparam logic [3:0] SS_64 = 4'b0001;

    typedef logic signed [SIGFIG-1:0] coord_t;

    // Anything that is not a legal one-hot rate falls back to one sample per pixel.
    function automatic coord_t step_of(input logic [3:0] ss);
        coord_t s;
        s = '0;
        case (ss)
            SS_1:    s[RADIX]   = 1'b1;
            SS_4:    s[RADIX-1] = 1'b1;
            SS_16:   s[RADIX-2] = 1'b1;
            SS_64:   s[RADIX-3] = 1'b1;
            default: s[RADIX]   = 1'b1;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sample_iter_ctrl_iter_step.sv
// Raster-order next-sample computation for the sample iterator.
// Sums are one bit wider than the coordinates so compares never wrap.
module iter_step
    import sample_iter_ctrl_pkg::*;
(
    input  coord_t x,
    input  coord_t y,
    input  coord_t ll_x,
    input  coord_t ur_x,
    input  coord_t ur_y,
    input  coord_t step,
    output coord_t nx,
    output coord_t ny,
    output logic   last
);

    logic signed [SIGFIG:0] x_sum;
    logic signed [SIGFIG:0] y_sum;
    logic signed [SIGFIG:0] ur_xw;
    logic signed [SIGFIG:0] ur_yw;
    logic                   x_fits;

    assign x_sum  = $signed({x[SIGFIG-1], x}) + $signed({step[SIGFIG-1], step});
    assign y_sum  = $signed({y[SIGFIG-1], y}) + $signed({step[SIGFIG-1], step});
    assign ur_xw  = $signed({ur_x[SIGFIG-1], ur_x});
    assign ur_yw  = $signed({ur_y[SIGFIG-1], ur_y});

    assign x_fits = x_sum <= ur_xw;

    assign nx   = x_fits ? coord_t'(x_sum[SIGFIG-1:0]) : ll_x;
    assign ny   = x_fits ? y : coord_t'(y_sum[SIGFIG-1:0]);
    assign last = !x_fits && (y_sum > ur_yw);

endmodule

// File: rtl/sample_iter_ctrl.sv
// Walks every subsample of a triangle's bounding box in raster order.
// Define ITER_STATS_EN to add saturating triangle/sample/drop counters.
module sample_iter_ctrl
    import sample_iter_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
`ifdef ITER_STATS_EN
    ,
    output logic        [31:0]       tri_cnt_R14U,
    output logic        [31:0]       samp_cnt_R14U,
    output logic        [31:0]       drop_cnt_R14U
`endif
);

    state_t state;
    coord_t ll_x;
    coord_t ur_x;
    coord_t ur_y;
    coord_t step;
    coord_t nx;
    coord_t ny;
    logic   last;
    logic   box_ok;
    logic   accept;

    assign box_ok = (box_R13S[1][0] >= box_R13S[0][0])
                 && (box_R13S[1][1] >= box_R13S[0][1]);
    assign accept = (state == WAIT) && validTri_R13H;

    iter_step u_step (
        .x    (sample_R14S[0]),
        .y    (sample_R14S[1]),
        .ll_x (ll_x),
        .ur_x (ur_x),
        .ur_y (ur_y),
        .step (step),
        .nx   (nx),
        .ny   (ny),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= WAIT;
            halt_RnnnnL    <= 1'b1;
            validSamp_R14H <= 1'b0;
            tri_R14S       <= '{default: '0};
            color_R14U     <= '{default: '0};
            sample_R14S    <= '{default: '0};
            ll_x           <= '0;
            ur_x           <= '0;
            ur_y           <= '0;
            step           <= '0;
        end else begin
            unique case (state)
                WAIT: begin
                    if (validTri_R13H) begin
                        tri_R14S   <= tri_R13S;
                        color_R14U <= color_R13U;
                        ll_x       <= box_R13S[0][0];
                        ur_x       <= box_R13S[1][0];
                        ur_y       <= box_R13S[1][1];
                        step       <= step_of(subSample_RnnnnU);
                        if (box_ok) begin
                            sample_R14S[0] <= box_R13S[0][0];
                            sample_R14S[1] <= box_R13S[0][1];
                            state          <= TEST;
                            halt_RnnnnL    <= 1'b0;
                            validSamp_R14H <= 1'b1;
                        end
                    end
                end
                TEST: begin
                    if (last) begin
                        state          <= WAIT;
                        halt_RnnnnL    <= 1'b1;
                        validSamp_R14H <= 1'b0;
                    end else begin
                        sample_R14S[0] <= nx;
                        sample_R14S[1] <= ny;
                    end
                end
                default: begin
                    state          <= WAIT;
                    halt_RnnnnL    <= 1'b1;
                    validSamp_R14H <= 1'b0;
                end
            endcase
        end
    end

`ifdef ITER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_cnt_R14U  <= '0;
            samp_cnt_R14U <= '0;
            drop_cnt_R14U <= '0;
        end else begin
            if (accept && box_ok) tri_cnt_R14U <= sat_inc(tri_cnt_R14U);
            if (accept && !box_ok) drop_cnt_R14U <= sat_inc(drop_cnt_R14U);
            if (state == TEST) samp_cnt_R14U <= sat_inc(samp_cnt_R14U);
        end
    end
`endif

endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Scoreboard bench for sample_iter_ctrl: directed plan cases plus random boxes.
// Build with ITER_STATS_EN defined to also check the statistics counters.
module tb_sample_iter_ctrl;
    import sample_iter_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13U [COLORS];
    logic signed [SIGFIG-1:0] box_R13S [2][2];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnnnU;
    logic                     halt_RnnnnL;
    logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R14U [COLORS];
    logic signed [SIGFIG-1:0] sample_R14S [2];
    logic                     validSamp_R14H;
`ifdef ITER_STATS_EN
    logic [31:0] tri_cnt_R14U;
    logic [31:0] samp_cnt_R14U;
    logic [31:0] drop_cnt_R14U;
`endif

    sample_iter_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
`ifdef ITER_STATS_EN
        ,
        .tri_cnt_R14U     (tri_cnt_R14U),
        .samp_cnt_R14U    (samp_cnt_R14U),
        .drop_cnt_R14U    (drop_cnt_R14U)
`endif
    );

    typedef struct packed {
        logic signed [SIGFIG-1:0] x;
        logic signed [SIGFIG-1:0] y;
        logic [8:0][SIGFIG-1:0]   t;
        logic [2:0][SIGFIG-1:0]   c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   cyc = 0;
    bit   started = 0;
    int   prev_acc = 0;
    int   prev_s = 0;
    bit   chain = 0;
    int   exp_tri = 0;
    int   exp_samp = 0;
    int   exp_drop = 0;

    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Step size straight from the rate table: pixel / sqrt(samples per pixel).
    function automatic int step_for(input logic [3:0] r);
        case (r)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Monitor: pops one expectation per valid sample.
    initial forever begin
        @(negedge clk);
        if (started && rst) begin
            chk("halt_is_not_valid", halt_RnnnnL, !validSamp_R14H);
            if (validSamp_R14H === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: got (%0d,%0d) expected none",
                             sample_R14S[0], sample_R14S[1]);
                end else begin
                    exp_t e;
                    bit ok;
                    e = q.pop_front();
                    pops++;
                    ok = (sample_R14S[0] === e.x) && (sample_R14S[1] === e.y);
                    for (int v = 0; v < VERTS; v++)
                        for (int a = 0; a < AXIS; a++)
                            if (tri_R14S[v][a] !== e.t[v*3+a]) ok = 0;
                    for (int c = 0; c < COLORS; c++)
                        if (color_R14U[c] !== e.c[c]) ok = 0;
                    if (!ok) begin
                        errors++;
                        $display("FAIL sample: got (%0d,%0d) tri0=%0d col0=%0d expected (%0d,%0d) tri0=%0d col0=%0d",
                                 sample_R14S[0], sample_R14S[1], tri_R14S[0][0], color_R14U[0],
                                 e.x, e.y, e.t[0], e.c[0]);
                    end
                end
            end
        end
    end

    // Present a triangle at a negedge and hold it until the controller takes it.
    task automatic send(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] rate);
        exp_t e;
        int n;
        int st;
        int s;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) begin
                tri_R13S[v][a] = SIGFIG'($urandom());
                e.t[v*3+a] = tri_R13S[v][a];
            end
        for (int c = 0; c < COLORS; c++) begin
            color_R13U[c] = SIGFIG'($urandom());
            e.c[c] = color_R13U[c];
        end
        box_R13S[0][0]   = SIGFIG'(llx);
        box_R13S[0][1]   = SIGFIG'(lly);
        box_R13S[1][0]   = SIGFIG'(urx);
        box_R13S[1][1]   = SIGFIG'(ury);
        subSample_RnnnnU = rate;
        validTri_R13H    = 1'b1;
        n = 0;
        while (halt_RnnnnL !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_bound", halt_RnnnnL, 1);
        if (halt_RnnnnL !== 1'b1) begin
            validTri_R13H = 1'b0;
            chain = 0;
            return;
        end
        if (chain) chk("accept_spacing", cyc - prev_acc, (prev_s == 0) ? 1 : prev_s + 1);
        st = step_for(rate);
        s = 0;
        if (urx >= llx && ury >= lly) begin
            for (int y = lly; y <= ury; y += st)
                for (int x = llx; x <= urx; x += st) begin
                    e.x = SIGFIG'(x);
                    e.y = SIGFIG'(y);
                    q.push_back(e);
                    s++;
                end
            exp_tri++;
            exp_samp += s;
        end else begin
            exp_drop++;
        end
        prev_acc = cyc;
        prev_s = s;
        chain = 1;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        validTri_R13H = 1'b0;
        chain = 0;
        n = 0;
        while (q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        int p0;
        int st;
        int llx;
        int lly;
        int w;
        int h;
        logic [3:0] rates [6];
        rates = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1100};
        tri_R13S         = '{default: '0};
        color_R13U       = '{default: '0};
        box_R13S         = '{default: '0};
        validTri_R13H    = 1'b0;
        subSample_RnnnnU = 4'b1000;
        repeat (3) @(negedge clk);
        chk("reset_halt", halt_RnnnnL, 1);
        chk("reset_valid", validSamp_R14H, 0);
        chk("reset_sample_x", sample_R14S[0], 0);
        chk("reset_sample_y", sample_R14S[1], 0);
        chk("reset_tri", tri_R14S[2][2], 0);
        chk("reset_color", color_R14U[1], 0);
        rst = 1'b1;
        started = 1;
        @(negedge clk);

        send(0, 0, 2048, 1024, 4'b1000);
        send(0, 0, 512, 512, 4'b0100);
        send(4096, 4096, 4096, 4096, 4'b1000);
        send(4096, 4096, 8192, 4096, 4'b1000);
        send(1024, 0, 0, 1024, 4'b1000);
        send(-1024, -1024, 0, 0, 4'b1000);
        send(0, 0, 256, 128, 4'b0001);
        send(8191 * 1024, 0, 8191 * 1024, 1024, 4'b1000);
        send(0, 0, 512, 256, 4'b0010);
        drain();

        p0 = pops;
        send(0, 0, 2048, 1024, 4'b1000);
        validTri_R13H = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pops - p0 >= 2) break;
            @(negedge clk);
            #1;
        end
        chk("second_sample_seen", pops - p0, 2);
        rst = 1'b0;
        #1;
        chk("mid_reset_valid", validSamp_R14H, 0);
        chk("mid_reset_halt", halt_RnnnnL, 1);
        chk("mid_reset_sample", sample_R14S[0], 0);
        q.delete();
        exp_tri = 0;
        exp_samp = 0;
        exp_drop = 0;
        chain = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(3072, -2048, 5120, 0, 4'b1000);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                validTri_R13H = 1'b0;
                chain = 0;
                repeat ($urandom_range(1, 8)) @(negedge clk);
            end
            subSample_RnnnnU = rates[$urandom_range(0, 5)];
            st  = step_for(subSample_RnnnnU);
            llx = ($urandom_range(0, 16) - 8) * st;
            lly = ($urandom_range(0, 16) - 8) * st;
            w   = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
            h   = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
            send(llx, lly, llx + w * st, lly + h * st, subSample_RnnnnU);
        end
        drain();
        repeat (3) @(negedge clk);
        chk("idle_halt", halt_RnnnnL, 1);
        chk("idle_valid", validSamp_R14H, 0);
`ifdef ITER_STATS_EN
        chk("tri_cnt", tri_cnt_R14U, exp_tri);
        chk("samp_cnt", samp_cnt_R14U, exp_samp);
        chk("drop_cnt", drop_cnt_R14U, exp_drop);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
